// File: rtl/input_buf_pkg.sv
// input_buf_pkg: shared types and defaults for the ping-pong input buffer
// scheduler.
//   bank_state_e : life cycle of one ping-pong half
//   rd_fsm_e     : drain sequencer states
package input_buf_pkg;
  localparam int DEF_BANK_DEPTH = 128;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILLING,
    B_FULL,
    B_DRAINING
  } bank_state_e;

  typedef enum logic {
    IDLE,
    RUN
  } rd_fsm_e;
endpackage

// File: rtl/input_buf_rd_skew.sv
// input_buf_rd_skew: diagonal read skew for the systolic array feed.
// Row r lags row 0 by r cycles, so row r reads offset (rcnt - r) while that
// offset lies in [0, nrow).
//   run_i     : drain sequence active
//   rcnt_i    : drain cycle counter
//   nrow_i    : rows in the tile being drained
//   base_i    : base address of the bank being drained
//   rd_en_o   : per-row read enable
//   rd_addr_o : per-row read address, 0 when the row is not reading
module input_buf_rd_skew #(
  parameter int SYS_ROW    = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int CW         = 8,
  parameter int RCW        = 8
) (
  input  logic                  run_i,
  input  logic [RCW-1:0]        rcnt_i,
  input  logic [CW-1:0]         nrow_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  output logic [SYS_ROW-1:0]    rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o [0:SYS_ROW-1]
);
  for (genvar r = 0; r < SYS_ROW; r++) begin : g_row
    // One extra bit so a negative offset (row not started yet) shows up as
    // the sign bit instead of wrapping.
    logic [RCW:0] ofs;
    logic         hit;
    assign ofs          = {1'b0, rcnt_i} - (RCW+1)'(r);
    assign hit          = run_i && !ofs[RCW] && (ofs[RCW-1:0] < RCW'(nrow_i));
    assign rd_en_o[r]   = hit;
    assign rd_addr_o[r] = hit ? base_i + ADDR_WIDTH'(ofs[RCW-1:0]) : '0;
  end
endmodule

// File: rtl/input_buf_sched.sv
// input_buf_sched: ping-pong input buffer scheduler for a systolic array.
// A producer fills one bank row-vector by row-vector while the systolic
// controller drains the other bank with a diagonal per-row skew.
//   clk, rst       : clock, synchronous active-high reset
//   num_row        : rows per tile (legal 1..BANK_DEPTH), latched per tile
//   ld_valid/ready : producer handshake, one row vector per beat
//   rd_req         : level request to drain the next full bank
//   rd_busy/done   : drain in progress / last drain cycle
//   wr_en/wr_addr  : per-row mem_arr write port
//   rd_en/rd_addr  : per-row mem_arr read port (skewed)
//   bank_full      : bank holds a complete tile (awaiting or in drain)
//   cfg_err        : num_row out of range
module input_buf_sched
  import input_buf_pkg::*;
#(
  parameter int SYS_ROW    = 16,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BANK_DEPTH = DEF_BANK_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           num_row,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  rd_req,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic [SYS_ROW-1:0]    wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr [0:SYS_ROW-1],
  output logic [SYS_ROW-1:0]    rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr [0:SYS_ROW-1],
  output logic [1:0]            bank_full,
  output logic                  cfg_err
);
  localparam int CW   = $clog2(BANK_DEPTH + 1);
  localparam int RCW  = $clog2(BANK_DEPTH + SYS_ROW);
  localparam int SKEW = SYS_ROW - 1;
  localparam logic [ADDR_WIDTH-1:0] BASE1 = ADDR_WIDTH'(BANK_DEPTH);

  bank_state_e    bank_q [2];
  bank_state_e    bank_d [2];
  logic [CW-1:0]  nrow_q [2];
  logic [CW-1:0]  nrow_d [2];
  logic           wb_q, wb_d, rb_q, rb_d;
  logic [CW-1:0]  wcnt_q, wcnt_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  rd_fsm_e        fsm_q, fsm_d;

  logic                  wr_open, acc, wr_last, rd_last;
  logic [CW-1:0]         nrow_w;
  logic [ADDR_WIDTH-1:0] wa;

  assign cfg_err = (num_row == 32'd0) || (num_row > 32'(BANK_DEPTH));
  assign wr_open = (bank_q[wb_q] == B_EMPTY) || (bank_q[wb_q] == B_FILLING);
  assign ld_ready = !rst && !cfg_err && wr_open;
  assign acc = ld_valid && ld_ready;

  // The first beat of a tile uses the live num_row; later beats use the
  // latched copy so a mid-tile num_row change cannot move the end point.
  assign nrow_w  = (bank_q[wb_q] == B_EMPTY) ? CW'(num_row) : nrow_q[wb_q];
  assign wr_last = (wcnt_q == nrow_w - CW'(1));
  // Drain lasts nrow + SYS_ROW - 1 cycles (last row trails by SYS_ROW-1).
  assign rd_last = (rcnt_q + RCW'(1) == RCW'(nrow_q[rb_q]) + RCW'(SKEW));

  always_comb begin
    bank_d = bank_q;
    nrow_d = nrow_q;
    wb_d   = wb_q;
    wcnt_d = wcnt_q;
    rb_d   = rb_q;
    rcnt_d = rcnt_q;
    fsm_d  = fsm_q;
    // Fill and drain never touch the same bank in one cycle: the filler only
    // works on EMPTY/FILLING, the drainer only on FULL/DRAINING.
    if (acc) begin
      if (bank_q[wb_q] == B_EMPTY) nrow_d[wb_q] = CW'(num_row);
      if (wr_last) begin
        bank_d[wb_q] = B_FULL;
        wcnt_d       = '0;
        wb_d         = !wb_q;
      end else begin
        bank_d[wb_q] = B_FILLING;
        wcnt_d       = wcnt_q + CW'(1);
      end
    end
    unique case (fsm_q)
      IDLE: begin
        if (rd_req && bank_q[rb_q] == B_FULL) begin
          fsm_d        = RUN;
          bank_d[rb_q] = B_DRAINING;
          rcnt_d       = '0;
        end
      end
      RUN: begin
        if (rd_last) begin
          fsm_d        = IDLE;
          bank_d[rb_q] = B_EMPTY;
          rb_d         = !rb_q;
          rcnt_d       = '0;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      nrow_q[0] <= '0;
      nrow_q[1] <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      fsm_q     <= IDLE;
    end else begin
      bank_q <= bank_d;
      nrow_q <= nrow_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      fsm_q  <= fsm_d;
    end
  end

  // Every row writes the same address: one row vector per beat.
  assign wa    = (wb_q ? BASE1 : '0) + ADDR_WIDTH'(wcnt_q);
  assign wr_en = {SYS_ROW{acc}};
  for (genvar r = 0; r < SYS_ROW; r++) begin : g_wr
    assign wr_addr[r] = acc ? wa : '0;
  end

  assign rd_busy = !rst && (fsm_q == RUN);
  assign rd_done = rd_busy && rd_last;

  for (genvar b = 0; b < 2; b++) begin : g_full
    assign bank_full[b] = !rst && ((bank_q[b] == B_FULL) || (bank_q[b] == B_DRAINING));
  end

  input_buf_rd_skew #(
    .SYS_ROW   (SYS_ROW),
    .ADDR_WIDTH(ADDR_WIDTH),
    .CW        (CW),
    .RCW       (RCW)
  ) u_skew (
    .run_i    (rd_busy),
    .rcnt_i   (rcnt_q),
    .nrow_i   (nrow_q[rb_q]),
    .base_i   (rb_q ? BASE1 : '0),
    .rd_en_o  (rd_en),
    .rd_addr_o(rd_addr)
  );
endmodule
